// File: rtl/rv_csr_unit_pkg.sv
// rtl/rv_csr_unit_pkg.sv - shared widths, CSR op encodings and FP-CSR address constants
package rv_csr_unit_pkg;

    localparam int UUID_BITS     = 8;
    localparam int NUM_THREADS   = 4;
    localparam int NUM_WARPS     = 4;
    localparam int NW_BITS       = 2;
    localparam int CSR_ADDR_BITS = 12;
    localparam int LANE_BITS     = $clog2(NUM_THREADS);

    // Encoding 3 is reserved and behaves as set-bits.
    typedef enum logic [1:0] {
        CSR_OP_RW  = 2'd0,
        CSR_OP_RS  = 2'd1,
        CSR_OP_RC  = 2'd2,
        CSR_OP_RSV = 2'd3
    } csr_op_e;

    localparam logic [CSR_ADDR_BITS-1:0] CSR_FFLAGS   = 12'h001;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_FRM      = 12'h002;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_FCSR     = 12'h003;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_MSCRATCH = 12'h340;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_MEPC     = 12'h341;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_MCYCLE   = 12'hB00;

    function automatic logic is_fp_csr(input logic [CSR_ADDR_BITS-1:0] addr);
        return (addr == CSR_FFLAGS) || (addr == CSR_FRM) || (addr == CSR_FCSR);
    endfunction

endpackage

// File: rtl/rv_csr_unit_if.sv
// rtl/rv_csr_unit_if.sv - dispatch request, CSR array ports and commit response bundle
//   slave  : the CSR unit side (takes requests, drives CSR ports and the response)
//   master : dispatch / CSR array / commit side
interface rv_csr_unit_if;
    import rv_csr_unit_pkg::*;

    logic                          req_valid;
    logic                          req_ready;
    logic [UUID_BITS-1:0]          req_uuid;
    logic [NW_BITS-1:0]            req_wid;
    logic [NUM_THREADS-1:0]        req_tmask;
    logic [31:0]                   req_PC;
    logic [1:0]                    req_op;
    logic                          req_use_imm;
    logic [4:0]                    req_rs1;
    logic [NUM_THREADS*32-1:0]     req_rs1_data;
    logic [CSR_ADDR_BITS-1:0]      req_addr;
    logic [4:0]                    req_rd;
    logic                          req_wb;

    logic [NUM_WARPS-1:0]          fpu_pending;

    logic                          csr_read_enable;
    logic [UUID_BITS-1:0]          csr_read_uuid;
    logic [CSR_ADDR_BITS-1:0]      csr_read_addr;
    logic [NW_BITS-1:0]            csr_read_wid;
    logic [31:0]                   csr_read_data;

    logic                          csr_write_enable;
    logic [UUID_BITS-1:0]          csr_write_uuid;
    logic [CSR_ADDR_BITS-1:0]      csr_write_addr;
    logic [NW_BITS-1:0]            csr_write_wid;
    logic [31:0]                   csr_write_data;

    logic                          busy;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [UUID_BITS-1:0]          rsp_uuid;
    logic [NW_BITS-1:0]            rsp_wid;
    logic [NUM_THREADS-1:0]        rsp_tmask;
    logic [31:0]                   rsp_PC;
    logic [4:0]                    rsp_rd;
    logic                          rsp_wb;
    logic [NUM_THREADS*32-1:0]     rsp_data;

    modport slave (
        input  req_valid, req_uuid, req_wid, req_tmask, req_PC, req_op, req_use_imm,
               req_rs1, req_rs1_data, req_addr, req_rd, req_wb, fpu_pending,
               csr_read_data, rsp_ready,
        output req_ready, csr_read_enable, csr_read_uuid, csr_read_addr, csr_read_wid,
               csr_write_enable, csr_write_uuid, csr_write_addr, csr_write_wid, csr_write_data,
               busy, rsp_valid, rsp_uuid, rsp_wid, rsp_tmask, rsp_PC, rsp_rd, rsp_wb, rsp_data
    );

    modport master (
        output req_valid, req_uuid, req_wid, req_tmask, req_PC, req_op, req_use_imm,
               req_rs1, req_rs1_data, req_addr, req_rd, req_wb, fpu_pending,
               csr_read_data, rsp_ready,
        input  req_ready, csr_read_enable, csr_read_uuid, csr_read_addr, csr_read_wid,
               csr_write_enable, csr_write_uuid, csr_write_addr, csr_write_wid, csr_write_data,
               busy, rsp_valid, rsp_uuid, rsp_wid, rsp_tmask, rsp_PC, rsp_rd, rsp_wb, rsp_data
    );

endinterface

// File: rtl/rv_csr_unit_alu.sv
// rtl/rv_csr_unit_alu.sv - operand select, lowest-active-lane pick, read-modify-write value
//   i_op/i_use_imm/i_rs1/i_rs1_data/i_tmask : decoded request fields
//   i_old      : current CSR value from the read port
//   o_new      : value to write back
//   o_suppress : set/clear with rs1==0 (x0 or uimm 0) must not write
module rv_csr_unit_alu
    import rv_csr_unit_pkg::*;
(
    input  logic [1:0]               i_op,
    input  logic                     i_use_imm,
    input  logic [4:0]               i_rs1,
    input  logic [NUM_THREADS*32-1:0] i_rs1_data,
    input  logic [NUM_THREADS-1:0]   i_tmask,
    input  logic [31:0]              i_old,
    output logic [31:0]              o_new,
    output logic                     o_suppress
);

    logic [LANE_BITS-1:0] w_lane;
    logic [31:0]          w_src;

    // Scan from the top lane down so the lowest set bit wins; an empty mask stays on lane 0.
    always_comb begin
        w_lane = '0;
        for (int k = NUM_THREADS - 1; k >= 0; k--) begin
            if (i_tmask[k]) begin
                w_lane = LANE_BITS'(k);
            end
        end
    end

    always_comb begin
        w_src = i_use_imm ? {27'b0, i_rs1} : i_rs1_data[{w_lane, 5'b0} +: 32];
        case (csr_op_e'(i_op))
            CSR_OP_RW: o_new = w_src;
            CSR_OP_RC: o_new = i_old & ~w_src;
            default:   o_new = i_old | w_src;
        endcase
        o_suppress = (csr_op_e'(i_op) != CSR_OP_RW) && (i_rs1 == 5'd0);
    end

endmodule

// File: rtl/rv_csr_unit.sv
// rtl/rv_csr_unit.sv - CSR access issue: handshake, FP-CSR hazard stall, one-entry response register
//   clk, reset : clock, synchronous active-high reset
//   bus        : rv_csr_unit_if.slave (request, CSR read/write ports, commit response)
//   Optional feature macro: RV_CSR_FPU_HAZARD_EN (FP-CSR stall while the warp has FPU ops in flight)
module rv_csr_unit
    import rv_csr_unit_pkg::*;
#(
    parameter int CORE_ID = 0
) (
    input  logic         clk,
    input  logic         reset,
    rv_csr_unit_if.slave bus
);

    localparam int unused_core_id = CORE_ID;

    logic                      w_stall;
    logic                      w_fire;
    logic [31:0]               w_new;
    logic                      w_suppress;

    logic                      r_rsp_valid;
    logic [UUID_BITS-1:0]      r_rsp_uuid;
    logic [NW_BITS-1:0]        r_rsp_wid;
    logic [NUM_THREADS-1:0]    r_rsp_tmask;
    logic [31:0]               r_rsp_pc;
    logic [4:0]                r_rsp_rd;
    logic                      r_rsp_wb;
    logic [NUM_THREADS*32-1:0] r_rsp_data;

`ifdef RV_CSR_FPU_HAZARD_EN
    assign w_stall = is_fp_csr(bus.req_addr) & bus.fpu_pending[bus.req_wid];
`else
    logic [NUM_WARPS-1:0] w_unused_fpu;
    assign w_unused_fpu = bus.fpu_pending;
    assign w_stall      = 1'b0;
`endif

    // Holding ready low in reset keeps both CSR ports quiet during that cycle.
    assign bus.req_ready = ~reset & ~w_stall & (~r_rsp_valid | bus.rsp_ready);
    assign w_fire        = bus.req_valid & bus.req_ready;

    rv_csr_unit_alu u_alu (
        .i_op       (bus.req_op),
        .i_use_imm  (bus.req_use_imm),
        .i_rs1      (bus.req_rs1),
        .i_rs1_data (bus.req_rs1_data),
        .i_tmask    (bus.req_tmask),
        .i_old      (bus.csr_read_data),
        .o_new      (w_new),
        .o_suppress (w_suppress)
    );

    assign bus.csr_read_enable  = w_fire;
    assign bus.csr_read_uuid    = bus.req_uuid;
    assign bus.csr_read_addr    = bus.req_addr;
    assign bus.csr_read_wid     = bus.req_wid;

    assign bus.csr_write_enable = w_fire & ~w_suppress;
    assign bus.csr_write_uuid   = bus.req_uuid;
    assign bus.csr_write_addr   = bus.req_addr;
    assign bus.csr_write_wid    = bus.req_wid;
    assign bus.csr_write_data   = w_new;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_uuid  <= '0;
            r_rsp_wid   <= '0;
            r_rsp_tmask <= '0;
            r_rsp_pc    <= '0;
            r_rsp_rd    <= '0;
            r_rsp_wb    <= 1'b0;
            r_rsp_data  <= '0;
        end else if (w_fire) begin
            r_rsp_valid <= 1'b1;
            r_rsp_uuid  <= bus.req_uuid;
            r_rsp_wid   <= bus.req_wid;
            r_rsp_tmask <= bus.req_tmask;
            r_rsp_pc    <= bus.req_PC;
            r_rsp_rd    <= bus.req_rd;
            r_rsp_wb    <= bus.req_wb;
            r_rsp_data  <= {NUM_THREADS{bus.csr_read_data}};
        end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.busy      = r_rsp_valid;
    assign bus.rsp_uuid  = r_rsp_uuid;
    assign bus.rsp_wid   = r_rsp_wid;
    assign bus.rsp_tmask = r_rsp_tmask;
    assign bus.rsp_PC    = r_rsp_pc;
    assign bus.rsp_rd    = r_rsp_rd;
    assign bus.rsp_wb    = r_rsp_wb;
    assign bus.rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_rv_csr_unit.sv
// tb/tb_rv_csr_unit.sv - self-checking bench: CSR array model, per-cycle reference model, directed vectors
module tb_rv_csr_unit;
    import rv_csr_unit_pkg::*;

`ifdef RV_CSR_FPU_HAZARD_EN
    localparam bit HAZ = 1'b1;
`else
    localparam bit HAZ = 1'b0;
`endif

    logic clk;
    logic reset;
    rv_csr_unit_if bus ();

    rv_csr_unit #(.CORE_ID(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rep(input logic [31:0] v);
        return {4{v}};
    endfunction

    // CSR data array: combinational read, write at the clock edge, free-running cycle counter.
    logic [31:0] csr_mem [0:4095];

    always_comb bus.csr_read_data = csr_mem[bus.csr_read_addr];

    initial begin
        for (int i = 0; i < 4096; i++) csr_mem[i] <= 32'h0;
        csr_mem[CSR_FFLAGS] <= 32'h1F;
        csr_mem[CSR_MCYCLE] <= 32'd100;
        forever begin
            @(posedge clk);
            csr_mem[CSR_MCYCLE] <= csr_mem[CSR_MCYCLE] + 32'd1;
            if (bus.csr_write_enable) csr_mem[bus.csr_write_addr] <= bus.csr_write_data;
        end
    end

    // Reference model: what the unit must do this cycle, and what it must hold next cycle.
    logic        m_valid;
    logic [31:0] m_data;
    logic [7:0]  m_uuid;
    logic [1:0]  m_wid;
    logic [3:0]  m_tmask;
    logic [31:0] m_pc;
    logic [4:0]  m_rd;
    logic        m_wb;
    logic        e_stall, e_ready, e_fire, e_we;
    logic [31:0] e_src, e_old, e_new;
    int          lane;

    initial begin
        m_valid = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            e_stall = HAZ && (bus.req_addr inside {CSR_FFLAGS, CSR_FRM, CSR_FCSR})
                      && bus.fpu_pending[bus.req_wid];
            e_ready = !reset && !e_stall && (!m_valid || bus.rsp_ready);
            e_fire  = bus.req_valid && e_ready;
            lane = 0;
            for (int k = 0; k < 4; k++) begin
                if (bus.req_tmask[k]) begin
                    lane = k;
                    break;
                end
            end
            e_src = bus.req_use_imm ? {27'b0, bus.req_rs1} : bus.req_rs1_data[lane*32 +: 32];
            e_old = csr_mem[bus.req_addr];
            if (bus.req_op == 2'd0)      e_new = e_src;
            else if (bus.req_op == 2'd2) e_new = e_old & ~e_src;
            else                         e_new = e_old | e_src;
            e_we = e_fire && !(bus.req_op != 2'd0 && bus.req_rs1 == 5'd0);

            chk("req_ready", bus.req_ready, e_ready);
            chk("rd_en", bus.csr_read_enable, e_fire);
            chk("wr_en", bus.csr_write_enable, e_we);
            if (e_fire) begin
                chk("rd_addr", bus.csr_read_addr, bus.req_addr);
                chk("rd_uuid", bus.csr_read_uuid, bus.req_uuid);
                chk("rd_wid", bus.csr_read_wid, bus.req_wid);
            end
            if (e_we) begin
                chk("wr_data", bus.csr_write_data, e_new);
                chk("wr_addr", bus.csr_write_addr, bus.req_addr);
                chk("wr_wid", bus.csr_write_wid, bus.req_wid);
                chk("wr_uuid", bus.csr_write_uuid, bus.req_uuid);
            end
            chk("rsp_valid", bus.rsp_valid, m_valid);
            chk("busy", bus.busy, m_valid);
            if (m_valid) begin
                chk("rsp_data", bus.rsp_data, rep(m_data));
                chk("rsp_meta", {bus.rsp_uuid, bus.rsp_wid, bus.rsp_tmask, bus.rsp_PC, bus.rsp_rd, bus.rsp_wb},
                    {m_uuid, m_wid, m_tmask, m_pc, m_rd, m_wb});
            end

            if (reset) begin
                m_valid = 1'b0;
            end else if (e_fire) begin
                m_valid = 1'b1;
                m_data  = e_old;
                m_uuid  = bus.req_uuid;
                m_wid   = bus.req_wid;
                m_tmask = bus.req_tmask;
                m_pc    = bus.req_PC;
                m_rd    = bus.req_rd;
                m_wb    = bus.req_wb;
            end else if (bus.rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic imm, input logic [4:0] rs1,
                         input logic [11:0] addr, input logic [1:0] wid, input logic [3:0] tmask,
                         input logic [127:0] data, input logic [7:0] uuid);
        bus.req_valid    = 1'b1;
        bus.req_op       = op;
        bus.req_use_imm  = imm;
        bus.req_rs1      = rs1;
        bus.req_addr     = addr;
        bus.req_wid      = wid;
        bus.req_tmask    = tmask;
        bus.req_rs1_data = data;
        bus.req_uuid     = uuid;
        bus.req_rd       = uuid[4:0];
        bus.req_wb       = 1'b1;
        bus.req_PC       = 32'h1000 + {24'h0, uuid};
    endtask

    int lows;

    initial begin
        reset           = 1'b1;
        bus.rsp_ready   = 1'b1;
        bus.fpu_pending = '0;
        drive(2'd0, 1'b0, 5'd1, CSR_MEPC, 2'd0, 4'hF, rep(32'h5555), 8'h01);

        // Reset: no activity, cleared response register.
        tick();
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 1'b0);
        chk("rst_wr_en", bus.csr_write_enable, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_rsp_data", bus.rsp_data, 128'h0);
        chk("rst_rsp_meta", {bus.rsp_uuid, bus.rsp_PC, bus.rsp_rd, bus.rsp_wb}, '0);
        tick();
        reset = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_no_write", csr_mem[CSR_MEPC], 32'h0);

        // CSRRW MEPC <- 0x1234, then re-read via CSRRS x0.
        tick();
        drive(2'd0, 1'b0, 5'd1, CSR_MEPC, 2'd0, 4'hF, {96'h0, 32'h1234}, 8'h02);
        @(negedge clk);
        chk("rw_wdata", bus.csr_write_data, 32'h1234);
        tick();
        drive(2'd1, 1'b0, 5'd0, CSR_MEPC, 2'd0, 4'hF, rep(32'hFFFF), 8'h03);
        @(negedge clk);
        chk("rw_rsp_old", bus.rsp_data, rep(32'h0));
        chk("rw_mem", csr_mem[CSR_MEPC], 32'h1234);
        tick();
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("reread_rsp", bus.rsp_data, rep(32'h1234));

        // CSRRS x0 on the cycle counter: read only.
        tick();
        drive(2'd1, 1'b0, 5'd0, CSR_MCYCLE, 2'd2, 4'hF, rep(32'h1), 8'h04);
        @(negedge clk);
        chk("rs_x0_wr_en", bus.csr_write_enable, 1'b0);
        chk("rs_x0_rd_en", bus.csr_read_enable, 1'b1);
        tick();
        bus.req_valid = 1'b0;

        // CSRRCI uimm=3 on FFLAGS (0x1F).
        drive(2'd2, 1'b1, 5'd3, CSR_FFLAGS, 2'd1, 4'hF, rep(32'h0), 8'h05);
        tick();
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rci_rsp", bus.rsp_data, rep(32'h1F));
        chk("rci_mem", csr_mem[CSR_FFLAGS], 32'h1C);

        // Same request with FPU ops pending on warp 1 for four cycles.
        tick();
        bus.fpu_pending = 4'b0010;
        drive(2'd2, 1'b1, 5'd3, CSR_FFLAGS, 2'd1, 4'hF, rep(32'h0), 8'h06);
        lows = 0;
        repeat (4) begin
            @(negedge clk);
            if (!bus.req_ready) lows++;
            tick();
        end
        bus.fpu_pending = 4'b0000;
        @(negedge clk);
        chk("stall_release_ready", bus.req_ready, 1'b1);
        chk("stall_cycles", lows, HAZ ? 4 : 0);
        tick();
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("stall_rsp", bus.rsp_data, rep(32'h1C));
        chk("stall_uuid", bus.rsp_uuid, 8'h06);
        chk("stall_mem", csr_mem[CSR_FFLAGS], 32'h1C);

        // Lane pick: mask 0100 -> lane 2; empty mask -> lane 0; reserved op acts as set.
        tick();
        drive(2'd0, 1'b0, 5'd2, CSR_MSCRATCH, 2'd3, 4'b0100,
              {32'hD, 32'hC, 32'hB, 32'hA}, 8'h07);
        tick();
        drive(2'd0, 1'b0, 5'd2, 12'h305, 2'd3, 4'b0000,
              {32'hD, 32'hC, 32'hB, 32'hA}, 8'h08);
        tick();
        drive(2'd3, 1'b0, 5'd5, CSR_MSCRATCH, 2'd3, 4'b0001, {96'h0, 32'hF0}, 8'h09);
        tick();
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("lane2_then_rsv", csr_mem[CSR_MSCRATCH], 32'hFC);
        chk("lane0_empty_mask", csr_mem[12'h305], 32'hA);
        chk("rsv_rsp_old", bus.rsp_data, rep(32'hC));

        // Commit back-pressure for three cycles with a request waiting.
        tick();
        drive(2'd0, 1'b0, 5'd1, 12'h306, 2'd0, 4'hF, {96'h0, 32'h77}, 8'h40);
        tick();
        bus.rsp_ready = 1'b0;
        drive(2'd0, 1'b0, 5'd1, 12'h307, 2'd1, 4'hF, {96'h0, 32'h88}, 8'h41);
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", bus.req_ready, 1'b0);
            chk("bp_ports", {bus.csr_read_enable, bus.csr_write_enable}, 2'b00);
            chk("bp_hold", {bus.rsp_valid, bus.rsp_uuid}, {1'b1, 8'h40});
            tick();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("pop_fire_ready", bus.req_ready, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("pop_fire_valid", {bus.rsp_valid, bus.rsp_uuid}, {1'b1, 8'h41});
        chk("bp_mem", {csr_mem[12'h306], csr_mem[12'h307]}, {32'h77, 32'h88});

        // Reset with a response held and a request pending.
        tick();
        bus.rsp_ready = 1'b0;
        drive(2'd0, 1'b0, 5'd1, 12'h308, 2'd0, 4'hF, {96'h0, 32'h99}, 8'h50);
        tick();
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        drive(2'd0, 1'b0, 5'd1, 12'h309, 2'd0, 4'hF, {96'h0, 32'hAA}, 8'h51);
        @(negedge clk);
        chk("midrst_wr_en", bus.csr_write_enable, 1'b0);
        tick();
        reset = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("midrst_drop", {bus.rsp_valid, bus.rsp_uuid, bus.rsp_data}, '0);
        chk("midrst_mem", {csr_mem[12'h308], csr_mem[12'h309]}, {32'h99, 32'h0});

        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_csr_unit.md
# RV_csr_unit

Issuing side of the per-core CSR access protocol. Accepts decoded CSR instructions (CSRRW/CSRRS/CSRRC and immediate forms) from dispatch and drives the combinational read port and the write port of the CSR data array. It computes the read-modify-write value and returns the old CSR value to commit through a one-entry output register. It holds off FP-CSR accesses while the issuing warp has FPU operations in flight.

## Interface
Parameters:
- CORE_ID, 0, core index; passed through to nothing, kept for hierarchy consistency

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  dispatch request valid
- req_ready  out  1  request accepted when valid & ready
- req_uuid  in  `UUID_BITS  instruction id
- req_wid  in  `NW_BITS  warp id
- req_tmask  in  `NUM_THREADS  thread mask
- req_PC  in  32  instruction PC
- req_op  in  2  0=RW, 1=RS, 2=RC, 3=reserved (treated as RS)
- req_use_imm  in  1  immediate form; rs1 field is zero-extended uimm
- req_rs1  in  5  rs1 index / uimm
- req_rs1_data  in  `NUM_THREADS*32  rs1 per lane
- req_addr  in  `CSR_ADDR_BITS  CSR address
- req_rd, req_wb  in  5, 1  destination, writeback enable
- fpu_pending  in  `NUM_WARPS  per-warp FPU-in-flight
- csr_read_enable / csr_read_uuid / csr_read_addr / csr_read_wid  out  1/`UUID_BITS/`CSR_ADDR_BITS/`NW_BITS  read port
- csr_read_data  in  32  combinational read result
- csr_write_enable / csr_write_uuid / csr_write_addr / csr_write_wid / csr_write_data  out  1/`UUID_BITS/`CSR_ADDR_BITS/`NW_BITS/32  write port
- busy  out  1  output register holds a valid result
- rsp_valid  out  1  commit response valid
- rsp_ready  in  1  commit accepts
- rsp_uuid, rsp_wid, rsp_tmask, rsp_PC, rsp_rd, rsp_wb  out  as request  registered copies
- rsp_data  out  `NUM_THREADS*32  old CSR value replicated on every lane

## Operation
- Source operand S: req_use_imm ? {27'b0, req_rs1} : lane k of req_rs1_data, k = lowest set bit of req_tmask (lane 0 if mask is zero).
- New value: RW → S; RS → old | S; RC → old & ~S; old = csr_read_data.
- Write suppression: for RS/RC, csr_write_enable=0 when req_rs1==0 (covers x0 and uimm 0). RW always writes.
- Hazard: stall = FP-CSR address (`CSR_FFLAGS, `CSR_FRM, `CSR_FCSR) & fpu_pending[req_wid].
- req_ready = ~stall & (~rsp_valid | rsp_ready).
- fire = req_valid & req_ready. csr_read_enable = fire, csr_write_enable = fire & ~suppress. Read/write addr/wid/uuid driven from request fields unconditionally.
- On fire: output register loads metadata and rsp_data = {NUM_THREADS{old}}; rsp_valid←1. Else if rsp_ready: rsp_valid←0.
- busy = rsp_valid.

## Timing
- Reset: rsp_valid=0, rsp_data=0, all rsp_* metadata 0; busy=0. Write/read enables are 0 during reset because req_ready is forced 0 while reset is high.
- Latency: one cycle from fire to rsp_valid; throughput one per cycle when rsp_ready stays high.
- Write lands at the fire-cycle edge. A back-to-back request to the same CSR reads the updated value next cycle; no forwarding is needed.
- Simultaneous rsp pop and new fire: the register reloads and rsp_valid stays 1.
- rsp_valid=1 & rsp_ready=0: req_ready=0 and no CSR port activity.
- Stall does not depend on rsp state. A stalled request keeps req_ready=0 until fpu_pending[wid] clears, then fires the same cycle it clears.
- Reset mid-operation drops the held response. No write is issued in the reset cycle.

## Configuration
- RV_CSR_FPU_HAZARD_EN defined: FP-CSR stall logic as above.
- Undefined: stall tied 0; fpu_pending is ignored (port retained, unused).

## Structure
- Shared package/header (RV_define.vh): CSR op encodings (RW/RS/RC), FP-CSR address constants, width macros.
- Sub-module RV_csr_alu: combinational operand select, lowest-active-lane pick, new-value computation and suppression flag. The top level holds handshake, hazard and the output register.

## Test plan
- CSRRW, `CSR_MSCRATCH-class addr (`CSR_MEPC) old 0x0, rs1 lane0=0x1234 → write 0x1234, rsp_data all lanes 0x0 one cycle later; re-read returns 0x1234.
- CSRRS with rs1=x0 on `CSR_MCYCLE → csr_write_enable stays 0, rsp_data = current counter value.
- CSRRCI uimm=0x3 on `CSR_FFLAGS holding 0x1F, fpu_pending[wid]=0 → write 0x1C, rsp 0x1F.
- Same request with fpu_pending[wid]=1 for 4 cycles → req_ready=0 for 4 cycles, fires cycle 5. With the macro off, fires immediately.
- tmask=4'b0100, rs1 lanes {0xA,0xB,0xC,0xD}, CSRRW → write data 0xC (lane 2).
- rsp_ready=0 for 3 cycles with rsp_valid=1 → req_ready=0, no port enables, rsp fields stable; then a pop with a queued request gives a continuous rsp_valid.
